// File: rtl/product_pkg.sv
// Types and widths shared by the multiplier stage and the product accumulator.
package product_pkg;

    localparam int PROD_W        = 32;
    localparam int DEFAULT_ACC_W = 40;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } acc_state_t;

endpackage

// File: rtl/product_accumulator.sv
// Sums groups of unsigned products into one dot-product result.
// A group closes on BEATS products or on i_last; results are held on a ready/valid port.
module product_accumulator
    import product_pkg::*;
#(
    parameter  int IN_W  = PROD_W,
    parameter  int ACC_W = DEFAULT_ACC_W,
    parameter  int BEATS = 4,
    localparam int CNT_W = $clog2(BEATS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    output logic             i_ready,
    input  logic             i_valid,
    input  logic [IN_W-1:0]  i_payload,
    input  logic             i_last,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [ACC_W-1:0] o_payload,
    output logic [CNT_W-1:0] o_count,
    output logic             o_overflow
);

    acc_state_t       state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf_sticky;

    logic [ACC_W:0]   sum;
    logic             carry;
    logic [CNT_W-1:0] nxt_cnt;
    logic             close_group;

    // One bit wider than the accumulator so the carry out is visible
    always_comb begin
        sum         = {1'b0, acc} + (ACC_W + 1)'(i_payload);
        carry       = sum[ACC_W];
        nxt_cnt     = cnt + CNT_W'(1);
        close_group = (nxt_cnt == CNT_W'(BEATS)) || i_last;
    end

    assign i_ready = (state == ACCUM);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ACCUM;
            acc        <= '0;
            cnt        <= '0;
            ovf_sticky <= 1'b0;
            o_valid    <= 1'b0;
            o_payload  <= '0;
            o_count    <= '0;
            o_overflow <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (i_valid) begin
                        if (close_group) begin
                            o_payload  <= sum[ACC_W-1:0];
                            o_count    <= nxt_cnt;
                            o_overflow <= ovf_sticky | carry;
                            o_valid    <= 1'b1;
                            acc        <= '0;
                            cnt        <= '0;
                            ovf_sticky <= 1'b0;
                            state      <= HOLD;
                        end else begin
                            acc        <= sum[ACC_W-1:0];
                            cnt        <= nxt_cnt;
                            ovf_sticky <= ovf_sticky | carry;
                        end
                    end
                end
                // Result stays frozen until the consumer takes it
                HOLD: begin
                    if (o_ready) begin
                        o_valid <= 1'b0;
                        state   <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Directed and randomised-gap checks of product_accumulator at ACC_W 40/33 and BEATS 1.
module tb_product_accumulator;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_valid;
    logic [31:0] i_payload;
    logic        i_last;
    logic        o_ready;

    logic        i_ready_a, o_valid_a, o_overflow_a;
    logic [39:0] o_payload_a;
    logic [2:0]  o_count_a;
    logic        i_ready_b, o_valid_b, o_overflow_b;
    logic [32:0] o_payload_b;
    logic [2:0]  o_count_b;
    logic        i_ready_c, o_valid_c, o_overflow_c;
    logic [39:0] o_payload_c;
    logic [0:0]  o_count_c;

    int cmp_count = 0;
    int bad_count = 0;

    always #5 clk = ~clk;

    product_accumulator #(.IN_W(32), .ACC_W(40), .BEATS(4)) dut_a (
        .clk(clk), .reset(reset), .i_ready(i_ready_a), .i_valid(i_valid),
        .i_payload(i_payload), .i_last(i_last), .o_valid(o_valid_a), .o_ready(o_ready),
        .o_payload(o_payload_a), .o_count(o_count_a), .o_overflow(o_overflow_a)
    );

    product_accumulator #(.IN_W(32), .ACC_W(33), .BEATS(4)) dut_b (
        .clk(clk), .reset(reset), .i_ready(i_ready_b), .i_valid(i_valid),
        .i_payload(i_payload), .i_last(i_last), .o_valid(o_valid_b), .o_ready(o_ready),
        .o_payload(o_payload_b), .o_count(o_count_b), .o_overflow(o_overflow_b)
    );

    product_accumulator #(.IN_W(32), .ACC_W(40), .BEATS(1)) dut_c (
        .clk(clk), .reset(reset), .i_ready(i_ready_c), .i_valid(i_valid),
        .i_payload(i_payload), .i_last(i_last), .o_valid(o_valid_c), .o_ready(o_ready),
        .o_payload(o_payload_c), .o_count(o_count_c), .o_overflow(o_overflow_c)
    );

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        cmp_count++;
        if (actual !== expected) begin
            bad_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] payload, input logic last);
        i_valid   = 1'b1;
        i_payload = payload;
        i_last    = last;
        tick();
        i_valid   = 1'b0;
        i_last    = 1'b0;
    endtask

    // Reference model state for the random-gap run
    logic        m_hold;
    logic [39:0] m_acc, m_pay;
    logic [2:0]  m_cnt, m_out_cnt;
    logic        m_sticky, m_ovf;
    logic [40:0] m_sum;
    logic [2:0]  m_nxt;
    int          groups;
    int          cycles;

    initial begin
        reset     = 1'b1;
        i_valid   = 1'b0;
        i_payload = '0;
        i_last    = 1'b0;
        o_ready   = 1'b1;
        tick();
        tick();
        checkOutput("rst_valid",   o_valid_a,    0);
        checkOutput("rst_payload", o_payload_a,  0);
        checkOutput("rst_count",   o_count_a,    0);
        checkOutput("rst_ovf",     o_overflow_a, 0);
        checkOutput("rst_iready",  i_ready_a,    1);
        reset = 1'b0;
        tick();

        // Full group of BEATS products
        applyStimulus(15, 0);
        applyStimulus(100, 0);
        applyStimulus(7, 0);
        checkOutput("g4_no_early", o_valid_a, 0);
        applyStimulus(1, 0);
        checkOutput("g4_valid",   o_valid_a,    1);
        checkOutput("g4_payload", o_payload_a,  123);
        checkOutput("g4_count",   o_count_a,    4);
        checkOutput("g4_ovf",     o_overflow_a, 0);
        checkOutput("g4_iready",  i_ready_a,    0);
        tick();
        checkOutput("g4_taken", o_valid_a, 0);
        checkOutput("g4_ready", i_ready_a, 1);

        // Early close via i_last, then a fresh single-beat group
        applyStimulus(10, 0);
        applyStimulus(20, 1);
        checkOutput("last_payload", o_payload_a, 30);
        checkOutput("last_count",   o_count_a,   2);
        tick();
        applyStimulus(5, 1);
        checkOutput("single_payload", o_payload_a, 5);
        checkOutput("single_count",   o_count_a,   1);
        tick();

        // Wrap-around: 3 x 0xFFFFFFFF exceeds 33 bits but not 40
        applyStimulus(32'hFFFF_FFFF, 0);
        applyStimulus(32'hFFFF_FFFF, 0);
        applyStimulus(32'hFFFF_FFFF, 1);
        checkOutput("wrap33_payload", o_payload_b,  33'h0_FFFF_FFFD);
        checkOutput("wrap33_ovf",     o_overflow_b, 1);
        checkOutput("wrap33_count",   o_count_b,    3);
        checkOutput("wrap40_payload", o_payload_a,  40'h2_FFFF_FFFD);
        checkOutput("wrap40_ovf",     o_overflow_a, 0);
        tick();
        applyStimulus(1, 0);
        applyStimulus(1, 0);
        applyStimulus(1, 0);
        applyStimulus(1, 0);
        checkOutput("sticky_payload", o_payload_b,  4);
        checkOutput("sticky_ovf",     o_overflow_b, 0);
        tick();

        // Backpressure: result held, upstream stalled
        o_ready = 1'b0;
        applyStimulus(9, 1);
        checkOutput("bp_valid0", o_valid_a, 1);
        i_valid   = 1'b1;
        i_payload = 77;
        for (int k = 0; k < 5; k++) begin
            tick();
            checkOutput("bp_valid",   o_valid_a,   1);
            checkOutput("bp_payload", o_payload_a, 9);
            checkOutput("bp_iready",  i_ready_a,   0);
        end
        i_valid = 1'b0;
        o_ready = 1'b1;
        tick();
        checkOutput("bp_release_valid",  o_valid_a, 0);
        checkOutput("bp_release_iready", i_ready_a, 1);
        applyStimulus(3, 1);
        checkOutput("bp_no_leak_payload", o_payload_a, 3);
        checkOutput("bp_no_leak_count",   o_count_a,   1);
        tick();

        // Reset mid-group discards partial sum
        applyStimulus(20, 0);
        applyStimulus(30, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("midrst_valid",   o_valid_a,    0);
        checkOutput("midrst_payload", o_payload_a,  0);
        checkOutput("midrst_count",   o_count_a,    0);
        checkOutput("midrst_ovf",     o_overflow_a, 0);
        applyStimulus(1, 0);
        checkOutput("b1_valid",   o_valid_c,   1);
        checkOutput("b1_payload", o_payload_c, 1);
        checkOutput("b1_count",   o_count_c,   1);
        applyStimulus(2, 0);
        applyStimulus(3, 0);
        applyStimulus(4, 0);
        checkOutput("postrst_payload", o_payload_a, 10);
        checkOutput("postrst_count",   o_count_a,   4);
        tick();

        // Random gaps and backpressure against a reference model
        m_hold = 1'b0; m_acc = '0; m_cnt = '0; m_sticky = 1'b0;
        m_pay = '0; m_out_cnt = '0; m_ovf = 1'b0;
        groups = 0;
        cycles = 0;
        while (groups < 1000 && cycles < 40000) begin
            i_valid   = $urandom_range(0, 1) == 1;
            i_payload = $urandom;
            i_last    = $urandom_range(0, 3) == 0;
            o_ready   = $urandom_range(0, 1) == 1;
            if (!m_hold) begin
                if (i_valid) begin
                    m_sum = {1'b0, m_acc} + {9'd0, i_payload};
                    m_nxt = m_cnt + 3'd1;
                    if (m_nxt == 3'd4 || i_last) begin
                        m_pay = m_sum[39:0]; m_out_cnt = m_nxt; m_ovf = m_sticky | m_sum[40];
                        m_hold = 1'b1; m_acc = '0; m_cnt = '0; m_sticky = 1'b0;
                        groups++;
                    end else begin
                        m_acc = m_sum[39:0]; m_cnt = m_nxt; m_sticky = m_sticky | m_sum[40];
                    end
                end
            end else if (o_ready) begin
                m_hold = 1'b0;
            end
            tick();
            cycles++;
            checkOutput("rnd_valid",  o_valid_a, m_hold);
            checkOutput("rnd_iready", i_ready_a, !m_hold);
            if (m_hold) begin
                checkOutput("rnd_payload", o_payload_a,  m_pay);
                checkOutput("rnd_count",   o_count_a,    m_out_cnt);
                checkOutput("rnd_ovf",     o_overflow_a, m_ovf);
            end
        end
        checkOutput("rnd_groups_done", (groups >= 1000), 1);
        i_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", cmp_count, bad_count);
        $finish;
    end

endmodule
